// File: rtl/sort_sequencer.sv
// Time-multiplexed ascending sorter for one N-element unsigned vector.
// A vector is captured in IDLE, then one compare-exchange is issued per clock
// over a fixed bubble-sort schedule of N*(N-1)/2 compares. The result is then
// presented in DONE until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready is high only in IDLE, and out_valid is high only in DONE, so
// input and output transfers never overlap. in_valid outside IDLE and
// out_ready outside DONE have no effect.
module sort_sequencer #(
  parameter int WIDTH = 4,
  parameter int N     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic [7:0]           swap_cnt,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] IDX_MAX = CW'(N - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SORT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] elem [N];
  logic [CW-1:0]    pass;
  logic [CW-1:0]    idx;
  logic [CW-1:0]    idx_hi;
  logic [CW-1:0]    idx_last;
  logic             accept;
  logic             do_swap;
  logic             pass_end;
  logic             last_cmp;

  // The final index of each pass shrinks by one as the largest values settle.
  assign idx_hi    = idx + CW'(1);
  assign idx_last  = IDX_MAX - pass;
  assign pass_end  = (idx == idx_last);
  assign last_cmp  = pass_end && (pass == IDX_MAX);
  assign do_swap   = (state == S_SORT) && (elem[idx] > elem[idx_hi]);

  assign in_ready  = (state == S_IDLE) && rst_n;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept)    state_nx = S_SORT;
      S_SORT:  if (last_cmp)  state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default:                state_nx = S_IDLE;
    endcase
  end

  // Element registers, schedule counters and swap counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) elem[i] <= '0;
      swap_cnt <= 8'd0;
      pass     <= '0;
      idx      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            for (int i = 0; i < N; i++) elem[i] <= in_data[(N-1-i)*WIDTH +: WIDTH];
            swap_cnt <= 8'd0;
            pass     <= '0;
            idx      <= '0;
          end
        end
        S_SORT: begin
          if (do_swap) begin
            elem[idx]    <= elem[idx_hi];
            elem[idx_hi] <= elem[idx];
            swap_cnt     <= swap_cnt + 8'd1;
          end
          if (last_cmp) begin
            pass <= '0;
            idx  <= '0;
          end else if (pass_end) begin
            pass <= pass + CW'(1);
            idx  <= '0;
          end else begin
            idx  <= idx_hi;
          end
        end
        default: ;
      endcase
    end
  end

  // Pack element registers; element 0 occupies the MSB slice.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) out_data[(N-1-i)*WIDTH +: WIDTH] = elem[i];
  end

endmodule

// File: tb/tb_sort_sequencer.sv
// Bench for sort_sequencer (N=4, WIDTH=4): directed cases, backpressure, reset
// abort, randomized vectors and a back-to-back stream, all checked against a
// counting-sort / pair-count reference model.
module tb_sort_sequencer;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int DW = N * W;
  localparam int C  = N * (N - 1) / 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [7:0]    swap_cnt;
  logic          busy;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  sort_sequencer #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .swap_cnt  (swap_cnt),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Reference model.
  function automatic logic [W-1:0] elt(input logic [DW-1:0] v, input int i);
    return v[(N-1-i)*W +: W];
  endfunction

  function automatic logic [DW-1:0] model_sort(input logic [DW-1:0] v);
    int cnt[16];
    int pos;
    logic [DW-1:0] r;
    for (int k = 0; k < 16; k++) cnt[k] = 0;
    for (int i = 0; i < N; i++) cnt[elt(v, i)]++;
    r = '0;
    pos = 0;
    for (int val = 0; val < 16; val++)
      for (int c = 0; c < cnt[val]; c++) begin
        r[(N-1-pos)*W +: W] = 4'(val);
        pos++;
      end
    return r;
  endfunction

  function automatic int model_inv(input logic [DW-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (elt(v, i) > elt(v, j)) n++;
    return n;
  endfunction

  // Scoreboard check.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks.
  task automatic accept_vec(input string tag, input logic [DW-1:0] v);
    in_data  = v;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !in_ready; t++) begin
      @(posedge clk); #1;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [DW-1:0] ed, input int ec);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(C));
    check({tag, "_data"}, 32'(out_data), 32'(ed));
    check({tag, "_swaps"}, 32'(swap_cnt), 32'(ec));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
  endtask

  task automatic release_out(input string tag, input int ec);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_rise"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_swaps_held"}, 32'(swap_cnt), 32'(ec));
  endtask

  task automatic run_vec(input string tag, input logic [DW-1:0] v,
                         input logic [DW-1:0] ed, input int ec);
    accept_vec(tag, v);
    wait_result(tag, ed, ec);
    release_out(tag, ec);
  endtask

  // Directed and random sequence.
  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] bb[6];
    int k;
    int got;
    int last_acc;
    bit fire_in;
    bit fire_out;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_swap_cnt", 32'(swap_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic, sorted, reverse and duplicate vectors.
    run_vec("t1_mixed", 16'h9371, 16'h1379, 5);
    run_vec("t2_sorted", 16'h1234, 16'h1234, 0);
    run_vec("t2_reverse", 16'hFEDC, 16'hCDEF, 6);
    run_vec("t3_dups", 16'h5525, 16'h2555, 2);

    // Backpressure: hold DONE for 10 cycles with a new vector waiting.
    accept_vec("t4", 16'h8421);
    wait_result("t4", 16'h1248, 6);
    in_data  = 16'h3333;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_data", 32'(out_data), 32'h1248);
      check("t4_hold_in_ready", 32'(in_ready), 32'd0);
      check("t4_hold_swaps", 32'(swap_cnt), 32'd6);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("t4_release_valid", 32'(out_valid), 32'd0);
    check("t4_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("t4_next", 16'h3333, 0);
    release_out("t4_next", 0);

    // Reset during the third SORT cycle.
    accept_vec("t5", 16'h9371);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_data", 32'(out_data), 32'd0);
    check("t5_rst_swaps", 32'(swap_cnt), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("t5_idle_in_ready", 32'(in_ready), 32'd1);
    run_vec("t5_after", 16'h2103, 16'h0123, 3);

    // Randomized vectors against the model.
    repeat (20) begin
      v = DW'($urandom);
      run_vec("rnd", v, model_sort(v), model_inv(v));
    end

    // Back-to-back stream with in_valid and out_ready held high.
    for (int i = 0; i < 6; i++) bb[i] = DW'($urandom_range(0, 65535));
    k         = 0;
    got       = 0;
    last_acc  = -1;
    in_data   = bb[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        if (exp_q.size() > 0) check("t6_data", 32'(out_data), 32'(exp_q.pop_front()));
        else check("t6_unexpected_output", 32'(out_data), 32'hFFFFFFFF);
        got++;
      end
      if (fire_in) begin
        exp_q.push_back(model_sort(bb[k]));
        if (last_acc >= 0) check("t6_period", 32'(cyc - last_acc), 32'(C + 2));
        last_acc = cyc;
      end
      @(posedge clk); #1;
      if (fire_in) begin
        k++;
        if (k < 6) in_data = bb[k];
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("t6_outputs", 32'(got), 32'd6);
    check("t6_accepts", 32'(k), 32'd6);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
